range_sum_caller: RTL

Caller-side (consumer) end of the generator ready/valid protocol. It accepts a call request (base, limit, step), issues a start to a range-generator callee, and consumes every yielded value with a ready/valid handshake. It accumulates the sum and count of the yields, then returns {sum, count} to its own upstream caller through the same generator protocol, as a single-yield generator. It sits between a top-level driver and any range-style generator block.

---
 rtl/range_sum_caller_if.sv | 41 ++++
 rtl/range_sum_caller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/range_sum_caller_if.sv
// rtl/range_sum_caller_if.sv - generator-protocol bundle between a driver, range_sum_caller and its callee
//
// Purpose: groups the upstream call/result handshake and the downstream
// callee handshake of range_sum_caller into one interface.
// Upstream side : base/limit/step, _start, _ready in; _valid, _done, _0 (sum), _1 (count) out.
// Callee side   : g_base/g_limit/g_step, g_start, g_ready out; g_valid, g_done, g_0 in.
// Modports      : slave  = the range_sum_caller view,
//                 master = the environment view (driver plus callee).
interface range_sum_caller_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic                    _start;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _0;
  logic [CNT_WIDTH-1:0]    _1;

  logic signed [WIDTH-1:0] g_base;
  logic signed [WIDTH-1:0] g_limit;
  logic signed [WIDTH-1:0] g_step;
  logic                    g_start;
  logic                    g_ready;
  logic                    g_valid;
  logic                    g_done;
  logic signed [WIDTH-1:0] g_0;

  modport slave (
    input  base, limit, step, _start, _ready, g_valid, g_done, g_0,
    output _valid, _done, _0, _1, g_base, g_limit, g_step, g_start, g_ready
  );

  modport master (
    output base, limit, step, _start, _ready, g_valid, g_done, g_0,
    input  _valid, _done, _0, _1, g_base, g_limit, g_step, g_start, g_ready
  );
endinterface

// File: rtl/range_sum_caller.sv
// rtl/range_sum_caller.sv - calls a range generator, sums its yields and returns {sum, count}
//
// Purpose: consumer end of the generator ready/valid protocol. Latches a call
// (base, limit, step), pulses g_start to the callee for one cycle, accepts
// every yield while in COLLECT, and presents the wrapped sum and saturating
// count upstream as a single yield held until _ready.
// Ports:
//   _clock  - clock, all state on rising edge
//   _reset  - asynchronous active-low reset
//   bus     - range_sum_caller_if.slave (upstream call/result and callee signals)
module range_sum_caller #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic             _clock,
  input logic             _reset,
  range_sum_caller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALL, COLLECT, RESULT} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] g_base_q, g_base_d;
  logic signed [WIDTH-1:0] g_limit_q, g_limit_d;
  logic signed [WIDTH-1:0] g_step_q, g_step_d;
  logic                    g_start_q, g_start_d;
  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic signed [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [CNT_WIDTH-1:0]    res_cnt_q, res_cnt_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  // Accumulators including the yield offered this cycle, so a yield that
  // arrives together with g_done still lands in the result.
  logic signed [WIDTH-1:0] sum_inc;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  always_comb begin
    sum_inc = sum_q + (bus.g_valid ? bus.g_0 : '0);
    cnt_inc = (bus.g_valid && (count_q != CNT_MAX)) ? count_q + CNT_ONE : count_q;

    state_d   = state_q;
    g_base_d  = g_base_q;
    g_limit_d = g_limit_q;
    g_step_d  = g_step_q;
    g_start_d = g_start_q;
    sum_d     = sum_q;
    count_d   = count_q;
    res_sum_d = res_sum_q;
    res_cnt_d = res_cnt_q;
    valid_d   = valid_q;
    done_d    = done_q;

    case (state_q)
      IDLE: ;
      CALL: begin
        // Callee's g_valid/g_done still describe its previous call here.
        g_start_d = 1'b0;
        state_d   = COLLECT;
      end
      COLLECT: begin
        sum_d   = sum_inc;
        count_d = cnt_inc;
        if (bus.g_done) begin
          res_sum_d = sum_inc;
          res_cnt_d = cnt_inc;
          valid_d   = 1'b1;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (bus._ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new call aborts whatever is in flight and wins over all of the above.
    if (bus._start) begin
      g_base_d  = bus.base;
      g_limit_d = bus.limit;
      g_step_d  = bus.step;
      g_start_d = 1'b1;
      sum_d     = '0;
      count_d   = '0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      state_d   = CALL;
    end
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q   <= IDLE;
      g_base_q  <= '0;
      g_limit_q <= '0;
      g_step_q  <= '0;
      g_start_q <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      res_sum_q <= '0;
      res_cnt_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      g_base_q  <= g_base_d;
      g_limit_q <= g_limit_d;
      g_step_q  <= g_step_d;
      g_start_q <= g_start_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      res_sum_q <= res_sum_d;
      res_cnt_q <= res_cnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.g_base  = g_base_q;
  assign bus.g_limit = g_limit_q;
  assign bus.g_step  = g_step_q;
  assign bus.g_start = g_start_q;
  assign bus.g_ready = (state_q == COLLECT);
  assign bus._valid  = valid_q;
  assign bus._done   = done_q;
  assign bus._0      = res_sum_q;
  assign bus._1      = res_cnt_q;

endmodule
